// File: rtl/adder_arb_pkg.sv
// Shared types and sizing helpers for the round-robin shared-adder block.
package adder_arb_pkg;

    localparam int CNT_W           = 16;
    localparam int NUM_REQ_DEFAULT = 4;

    // Requester index width; a single-bit ID is kept even for two requesters.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int ID_W = id_width(NUM_REQ_DEFAULT);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

    typedef logic [CNT_W-1:0] acc_cnt_t;

endpackage

// File: rtl/brent_kung_adder_nc.sv
// Brent-Kung parallel-prefix adder, carry-out discarded (sum mod 2^W).
module brent_kung_adder_nc #(
    parameter int W = 32
)(
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o
);

    localparam int LOG = (W <= 2) ? 1 : $clog2(W);
    localparam int N2  = 1 << LOG;

    logic [N2-1:0] g, p;
    logic          unused_carry;

    // Up-sweep builds prefixes at 2^k-1 positions, down-sweep fills the rest.
    always_comb begin
        g = N2'(a_i & b_i);
        p = N2'(a_i ^ b_i);
        for (int l = 0; l < LOG; l++) begin
            for (int i = 0; i < N2; i++) begin
                if (((i + 1) % (2 << l)) == 0) begin
                    g[i] = g[i] | (p[i] & g[i - (1 << l)]);
                    p[i] = p[i] & p[i - (1 << l)];
                end
            end
        end
        for (int l = LOG - 2; l >= 0; l--) begin
            for (int i = 0; i < N2; i++) begin
                if ((((i + 1) % (2 << l)) == (1 << l)) && ((i + 1) > (2 << l))) begin
                    g[i] = g[i] | (p[i] & g[i - (1 << l)]);
                    p[i] = p[i] & p[i - (1 << l)];
                end
            end
        end
    end

    assign sum_o        = (a_i ^ b_i) ^ {g[W-2:0], 1'b0};
    assign unused_carry = ^{g[N2-1:W-1], p};

endmodule

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set request after last_grant, wrapping.
module rr_picker
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IDW    = id_width(NUM_REQ)
)(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     last_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDW-1:0]     idx_o
);

    logic found;

    always_comb begin
        found = 1'b0;
        idx_o = '0;
        gnt_o = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int j;
            j = (int'(last_i) + k) % NUM_REQ;
            if (!found && req_i[j]) begin
                found = 1'b1;
                idx_o = IDW'(j);
            end
        end
        if (found) gnt_o[idx_o] = 1'b1;
    end

endmodule

// File: rtl/adder_rr_arbiter.sv
// Round-robin arbitration of NUM_REQ requesters onto one shared adder with a
// one-entry registered response.
module adder_rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ADDER_WIDTH = 32,
    localparam int IDW        = id_width(NUM_REQ)
)(
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_REQ-1:0]                    req_valid,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic [NUM_REQ-1:0][ADDER_WIDTH-1:0]   req_operand_a,
    input  logic [NUM_REQ-1:0][ADDER_WIDTH-1:0]   req_operand_b,
    output logic                                  rsp_valid,
    input  logic                                  rsp_ready,
    output logic [ADDER_WIDTH-1:0]                rsp_sum,
    output logic [IDW-1:0]                        rsp_id,
    output acc_cnt_t                              accept_count
);

    out_state_e             state_q;
    logic [IDW-1:0]         last_grant_q;
    logic [ADDER_WIDTH-1:0] sum_q, sum_d;
    logic [IDW-1:0]         id_q;
    acc_cnt_t               cnt_q;

    logic [NUM_REQ-1:0]     gnt;
    logic [IDW-1:0]         gnt_idx;
    logic                   can_accept;
    logic                   accept;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req_i  (req_valid),
        .last_i (last_grant_q),
        .gnt_o  (gnt),
        .idx_o  (gnt_idx)
    );

    brent_kung_adder_nc #(.W(ADDER_WIDTH)) u_adder (
        .a_i   (req_operand_a[gnt_idx]),
        .b_i   (req_operand_b[gnt_idx]),
        .sum_o (sum_d)
    );

    assign can_accept = (state_q == EMPTY) || rsp_ready;
    // rst_n gating keeps req_ready low for the whole reset window.
    assign req_ready  = gnt & {NUM_REQ{can_accept && (|req_valid) && rst_n}};
    assign accept     = |(req_valid & req_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            last_grant_q <= IDW'(NUM_REQ - 1);
            sum_q        <= '0;
            id_q         <= '0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                EMPTY:   if (accept) state_q <= FULL;
                FULL:    if (!accept && rsp_ready) state_q <= EMPTY;
                default: state_q <= EMPTY;
            endcase
            if (accept) begin
                sum_q        <= sum_d;
                id_q         <= gnt_idx;
                last_grant_q <= gnt_idx;
                cnt_q        <= cnt_q + acc_cnt_t'(1);
            end
        end
    end

    assign rsp_valid    = (state_q == FULL);
    assign rsp_sum      = sum_q;
    assign rsp_id       = id_q;
    assign accept_count = cnt_q;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed bench for adder_rr_arbiter with a round-robin reference model and
// an expected-response queue.
module tb_adder_rr_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N-1:0]        req_valid, req_ready;
    logic [N-1:0][W-1:0] opa, opb;
    logic                rsp_valid, rsp_ready;
    logic [W-1:0]        rsp_sum;
    logic [1:0]          rsp_id;
    logic [15:0]         accept_count;

    typedef struct packed {
        logic [1:0]   id;
        logic [W-1:0] sum;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic        full_m;
    int          last_m;
    logic [15:0] cnt_m;

    always #5 clk = ~clk;

    adder_rr_arbiter #(.NUM_REQ(N), .ADDER_WIDTH(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_operand_a (opa),
        .req_operand_b (opb),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_sum       (rsp_sum),
        .rsp_id        (rsp_id),
        .accept_count  (accept_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare at negedge, advance the model, return 1ns after posedge.
    task automatic cycle();
        logic [N-1:0] er;
        int           g;
        logic         found;
        exp_t         e;
        @(negedge clk);
        chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, full_m});
        if (full_m && sb.size() > 0) begin
            chk("rsp_sum", 64'(rsp_sum), 64'(sb[0].sum));
            chk("rsp_id", 64'(rsp_id), 64'(sb[0].id));
        end
        chk("accept_count", 64'(accept_count), 64'(cnt_m));
        g = 0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!found && req_valid[(last_m + k) % N]) begin
                found = 1'b1;
                g = (last_m + k) % N;
            end
        end
        er = '0;
        if (found && (!full_m || rsp_ready)) er[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(er));
        if (full_m && rsp_ready && sb.size() > 0) e = sb.pop_front();
        if (er != '0) begin
            e.id  = 2'(g);
            e.sum = opa[g] + opb[g];
            sb.push_back(e);
            last_m = g;
            cnt_m  = cnt_m + 16'd1;
        end
        full_m = (er != '0) || (full_m && !rsp_ready);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '1;
        full_m    = 1'b0;
        last_m    = N - 1;
        cnt_m     = '0;
        sb.delete();
        @(negedge clk);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_sum", 64'(rsp_sum), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_accept_count", 64'(accept_count), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        req_valid = '0;
        rst_n     = 1'b1;
    endtask

    int           ord[6] = '{0, 1, 2, 3, 0, 1};
    logic [N-1:0] one;
    logic [W-1:0] hold_sum;
    logic [1:0]   hold_id;

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        req_valid = '0;
        opa       = '0;
        opb       = '0;
        #2;
        do_reset();

        // Single request, latency one
        rsp_ready = 1'b1;
        opa[0] = 32'd5;
        opb[0] = 32'd7;
        req_valid = 4'b0001;
        #1 chk("t1_req_ready", 64'(req_ready), 64'h1);
        cycle();
        req_valid = '0;
        chk("t1_sum", 64'(rsp_sum), 64'd12);
        chk("t1_count", 64'(accept_count), 64'd1);
        cycle();

        // Round-robin order with all requesters active
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            opa[i] = 32'(i * 100 + 1);
            opb[i] = 32'(i * 7);
        end
        req_valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            #1;
            one = 4'b0001 << ord[i];
            chk("t2_order", 64'(req_ready), 64'(one));
            cycle();
        end

        // Sum wraps with carry discarded
        req_valid = 4'b0001;
        opa[0] = 32'hFFFF_FFFF;
        opb[0] = 32'h0000_0002;
        cycle();
        chk("t3_wrap_sum", 64'(rsp_sum), 64'h1);
        chk("t3_wrap_id", 64'(rsp_id), 64'd0);

        // Backpressure while FULL
        opa[0] = 32'd9;
        opb[0] = 32'd1;
        req_valid = 4'b1111;
        cycle();
        rsp_ready = 1'b0;
        hold_sum = rsp_sum;
        hold_id  = rsp_id;
        repeat (5) cycle();
        chk("t4_hold_sum", 64'(rsp_sum), 64'(hold_sum));
        chk("t4_hold_id", 64'(rsp_id), 64'(hold_id));
        chk("t4_no_ready", 64'(req_ready), 64'd0);
        rsp_ready = 1'b1;
        #1 chk("t4_release", {63'd0, |req_ready}, 64'd1);
        cycle();
        cycle();

        // Asynchronous reset while holding a response
        rsp_ready = 1'b0;
        cycle();
        rst_n = 1'b0;
        #1;
        chk("t5_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("t5_rsp_sum", 64'(rsp_sum), 64'd0);
        chk("t5_req_ready", 64'(req_ready), 64'd0);
        full_m = 1'b0;
        last_m = N - 1;
        cnt_m  = '0;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        #1 chk("t5_first_grant", 64'(req_ready), 64'h1);
        cycle();
        req_valid = '0;
        cycle();

        // Accept counter wrap after 65537 accepts
        do_reset();
        rsp_ready = 1'b1;
        opa[0] = 32'd1;
        opb[0] = 32'd2;
        req_valid = 4'b0001;
        repeat (65537) cycle();
        req_valid = '0;
        chk("t6_count_wrap", 64'(accept_count), 64'd1);
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
